// File: rtl/sm_imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, byte counter width
// and the big-endian word packer used when a word is committed.
package sm_imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } iml_state_t;

    localparam int BCNT_W = 2;

    // Builds the word from the bytes already held plus the incoming byte.
    // Positions not yet filled (early ld_last) are zero-padded.
    function automatic logic [31:0] iml_pack(input logic [23:0]       partial,
                                             input logic [7:0]        b,
                                             input logic [BCNT_W-1:0] cnt);
        logic [31:0] w;
        case (cnt)
            2'd0:    w = {b, 24'h0};
            2'd1:    w = {partial[7:0], b, 16'h0};
            2'd2:    w = {partial[15:0], b, 8'h0};
            default: w = {partial, b};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sm_imem_loader_ram.sv
// Instruction RAM: 2**ADDR_WIDTH x 32, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module sm_imem_ram #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sm_imem_loader.sv
// Instruction-memory responder for sm_cpu with a valid/ready byte-stream load port.
// Holds the CPU in reset while a program is streamed in, then releases it.
module sm_imem_loader
    import sm_imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           imAddr,
    output logic [31:0]           imData,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic                  ld_last,
    input  logic [7:0]            ld_byte,
    output logic                  ld_ready,
    output logic                  cpu_rst_n,
    output logic [ADDR_WIDTH:0]   ld_words,
    output logic                  ld_ovf
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    iml_state_t          r_state;
    iml_state_t          w_next;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [23:0]         r_asm;
    logic [ADDR_WIDTH:0] r_words;
    logic                r_ovf;
    logic                r_cpu_rst_n;

    logic                w_accept;
    logic                w_word_done;
    logic                w_full;
    logic                w_we;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rdata;
    logic                w_unused_addr;

    // ld_start wins over a byte presented in the same cycle: that byte is discarded.
    assign w_accept    = ld_valid && (r_state == ST_LOAD) && !ld_start;
    assign w_word_done = w_accept && ((r_bcnt == 2'd3) || ld_last);
    assign w_full      = (r_words == DEPTH);
    assign w_we        = w_word_done && !w_full;
    assign w_wdata     = iml_pack(r_asm, ld_byte, r_bcnt);
    assign w_unused_addr = ^imAddr[31:ADDR_WIDTH];

    sm_imem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_words[ADDR_WIDTH-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (imAddr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_HOLD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ld_ready  = 1'b0;
        imData    = 32'h0;
        cpu_rst_n = r_cpu_rst_n;
        if (ld_start)                  w_next = ST_LOAD;
        else if (w_word_done && ld_last) w_next = ST_RUN;
        if (r_state == ST_LOAD) ld_ready = 1'b1;
        if (r_state == ST_RUN)  imData   = w_rdata;
    end

    // The write address doubles as the word count; it stops at DEPTH so
    // further word writes are dropped and flagged as overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt      <= '0;
            r_asm       <= '0;
            r_words     <= '0;
            r_ovf       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_cpu_rst_n <= (r_state == ST_RUN) && !ld_start;
            if (ld_start) begin
                r_bcnt  <= '0;
                r_asm   <= '0;
                r_words <= '0;
                r_ovf   <= 1'b0;
            end else if (w_accept) begin
                if (w_word_done) begin
                    r_bcnt <= '0;
                    r_asm  <= '0;
                    if (w_full) r_ovf   <= 1'b1;
                    else        r_words <= r_words + 1'b1;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                    r_asm  <= {r_asm[15:0], ld_byte};
                end
            end
        end
    end

    assign ld_words = r_words;
    assign ld_ovf   = r_ovf;

endmodule

// File: tb/tb_sm_imem_loader.sv
// Directed self-checking bench for sm_imem_loader: a 64-word instance and a
// 4-word instance share all inputs so the overflow boundary can be observed.
module tb_sm_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imAddr = '0;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_last = 1'b0;
    logic [7:0]  ld_byte = '0;

    logic [31:0] imData,  imData2;
    logic        ld_ready, ld_ready2;
    logic        cpu_rst_n, cpu_rst_n2;
    logic [6:0]  ld_words;
    logic [2:0]  ld_words2;
    logic        ld_ovf, ld_ovf2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sm_imem_loader #(.ADDR_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_byte(ld_byte),
        .ld_ready(ld_ready), .cpu_rst_n(cpu_rst_n), .ld_words(ld_words), .ld_ovf(ld_ovf)
    );

    sm_imem_loader #(.ADDR_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .imAddr(imAddr), .imData(imData2),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_last(ld_last), .ld_byte(ld_byte),
        .ld_ready(ld_ready2), .cpu_rst_n(cpu_rst_n2), .ld_words(ld_words2), .ld_ovf(ld_ovf2)
    );

    // All drive tasks are entered and left just after a negedge.
    task automatic put(input logic [7:0] b, input logic last);
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic start_pulse();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (ld_words !== 7'd0) begin failures++; $display("FAIL rst_ld_words got=%0d exp=0", ld_words); end
        checks++; if (ld_ovf !== 1'b0) begin failures++; $display("FAIL rst_ld_ovf got=%b exp=0", ld_ovf); end
        rst = 1'b0;
        imAddr = 32'd5;
        repeat (2) @(negedge clk);
        checks++; if (imData !== 32'h0) begin failures++; $display("FAIL hold_imdata got=%h exp=00000000", imData); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL hold_cpu_rst_n got=%b exp=0", cpu_rst_n); end
    endtask

    task automatic test_basic_load();
        start_pulse();
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL load_ld_ready got=%b exp=1", ld_ready); end
        checks++; if (imData !== 32'h0) begin failures++; $display("FAIL load_imdata got=%h exp=00000000", imData); end
        put(8'h24, 0); put(8'h08, 0); put(8'h00, 0); put(8'h05, 0);
        put(8'h24, 0); put(8'h09, 0); put(8'h00, 0); put(8'h07, 1);
        checks++; if (ld_words !== 7'd2) begin failures++; $display("FAIL basic_words got=%0d exp=2", ld_words); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_off got=%b exp=0", ld_ready); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL basic_rst_latency got=%b exp=0", cpu_rst_n); end
        @(negedge clk);
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL basic_rst_release got=%b exp=1", cpu_rst_n); end
        imAddr = 32'd0; #1;
        checks++; if (imData !== 32'h24080005) begin failures++; $display("FAIL basic_mem0 got=%h exp=24080005", imData); end
        imAddr = 32'd1; #1;
        checks++; if (imData !== 32'h24090007) begin failures++; $display("FAIL basic_mem1 got=%h exp=24090007", imData); end
        imAddr = 32'd65; #1;
        checks++; if (imData !== 32'h24090007) begin failures++; $display("FAIL basic_wrap got=%h exp=24090007", imData); end
    endtask

    task automatic test_partial_word();
        start_pulse();
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL reload_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        checks++; if (ld_words !== 7'd0) begin failures++; $display("FAIL reload_words got=%0d exp=0", ld_words); end
        put(8'hAA, 0); put(8'hBB, 0); put(8'hCC, 0); put(8'hDD, 0); put(8'h11, 0); put(8'h22, 1);
        @(negedge clk);
        checks++; if (ld_words !== 7'd2) begin failures++; $display("FAIL partial_words got=%0d exp=2", ld_words); end
        imAddr = 32'd0; #1;
        checks++; if (imData !== 32'hAABBCCDD) begin failures++; $display("FAIL partial_mem0 got=%h exp=aabbccdd", imData); end
        imAddr = 32'd1; #1;
        checks++; if (imData !== 32'h11220000) begin failures++; $display("FAIL partial_mem1 got=%h exp=11220000", imData); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            b = 8'(i);
            put(b, i == 19);
        end
        checks++; if (ld_words2 !== 3'd4) begin failures++; $display("FAIL ovf_words got=%0d exp=4", ld_words2); end
        checks++; if (ld_ovf2 !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ld_ovf2); end
        checks++; if (ld_words !== 7'd5) begin failures++; $display("FAIL big_words got=%0d exp=5", ld_words); end
        checks++; if (ld_ovf !== 1'b0) begin failures++; $display("FAIL big_ovf got=%b exp=0", ld_ovf); end
        imAddr = 32'd3; #1;
        checks++; if (imData2 !== 32'h0C0D0E0F) begin failures++; $display("FAIL ovf_mem3 got=%h exp=0c0d0e0f", imData2); end
        imAddr = 32'd4; #1;
        checks++; if (imData2 !== 32'h00010203) begin failures++; $display("FAIL ovf_drop got=%h exp=00010203", imData2); end
    endtask

    task automatic test_restart();
        start_pulse();
        checks++; if (ld_ovf2 !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ld_ovf2); end
        put(8'h11, 0); @(negedge clk); put(8'h22, 0); @(negedge clk);
        put(8'h33, 0); @(negedge clk); put(8'h44, 0); @(negedge clk);
        checks++; if (ld_words !== 7'd1) begin failures++; $display("FAIL toggle_words got=%0d exp=1", ld_words); end
        put(8'h55, 0); @(negedge clk); put(8'h66, 0);
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h77;
        @(negedge clk);
        ld_start = 1'b0; ld_valid = 1'b0;
        checks++; if (ld_words !== 7'd0) begin failures++; $display("FAIL restart_words got=%0d exp=0", ld_words); end
        put(8'hA1, 0); @(negedge clk); put(8'hA2, 0); @(negedge clk);
        put(8'hA3, 0); @(negedge clk); put(8'hA4, 0); @(negedge clk);
        put(8'hB1, 0); @(negedge clk); put(8'hB2, 1);
        checks++; if (ld_words !== 7'd2) begin failures++; $display("FAIL restart_final_words got=%0d exp=2", ld_words); end
        imAddr = 32'd0; #1;
        checks++; if (imData !== 32'hA1A2A3A4) begin failures++; $display("FAIL restart_mem0 got=%h exp=a1a2a3a4", imData); end
        imAddr = 32'd1; #1;
        checks++; if (imData !== 32'hB1B20000) begin failures++; $display("FAIL restart_mem1 got=%h exp=b1b20000", imData); end
    endtask

    task automatic test_async_reset();
        start_pulse();
        put(8'hCA, 0); put(8'hFE, 0); put(8'hBA, 0); put(8'hBE, 0);
        put(8'hDE, 0); put(8'hAD, 0); put(8'hBE, 0); put(8'hEF, 0);
        put(8'h99, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", ld_ready); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL arst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        checks++; if (ld_words !== 7'd0) begin failures++; $display("FAIL arst_words got=%0d exp=0", ld_words); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_pulse();
        put(8'h24, 0); put(8'h08, 0); put(8'h00, 0); put(8'h05, 1);
        @(negedge clk);
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL arst_reload_release got=%b exp=1", cpu_rst_n); end
        checks++; if (ld_words !== 7'd1) begin failures++; $display("FAIL arst_reload_words got=%0d exp=1", ld_words); end
        imAddr = 32'd0; #1;
        checks++; if (imData !== 32'h24080005) begin failures++; $display("FAIL arst_mem0 got=%h exp=24080005", imData); end
        imAddr = 32'd1; #1;
        checks++; if (imData !== 32'hDEADBEEF) begin failures++; $display("FAIL arst_retained got=%h exp=deadbeef", imData); end
        imAddr = 32'd2; #1;
        checks++; if (imData !== 32'h08090A0B) begin failures++; $display("FAIL arst_partial_lost got=%h exp=08090a0b", imData); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_word();
        test_overflow();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
